// File: rtl/timed_event_scheduler.sv
// timed_event_scheduler: parallel one-shot delay slots released one at a time on valid/ready; TIMED_EVENT_SCHEDULER_RR_EN selects round-robin release
module timed_event_scheduler #(
  parameter int NSLOTS = 4,
  parameter int DW = 16,
  parameter int TAGW = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_i,
  input  logic                      arm_valid_i,
  output logic                      arm_ready_o,
  input  logic [DW-1:0]             arm_delay_i,
  input  logic [TAGW-1:0]           arm_tag_i,
  output logic                      ev_valid_o,
  input  logic                      ev_ready_i,
  output logic [TAGW-1:0]           ev_tag_o,
  output logic [$clog2(NSLOTS)-1:0] ev_slot_o,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic [31:0]               fire_count_o
);
  localparam int SW = $clog2(NSLOTS);
  localparam logic [1:0] FREE = 2'd0, WAIT = 2'd1, PEND = 2'd2;
  logic [1:0]      st_q  [NSLOTS];
  logic [1:0]      st_d  [NSLOTS];
  logic [DW-1:0]   cnt_q [NSLOTS];
  logic [DW-1:0]   cnt_d [NSLOTS];
  logic [TAGW-1:0] tag_q [NSLOTS];
  logic [TAGW-1:0] tag_d [NSLOTS];
  logic [31:0]     fire_count_q, fire_count_d;
  logic [SW-1:0]   arm_idx, sel;
  logic            arm_hit, sel_hit, fire, arm;
  assign fire = sel_hit && ev_ready_i;
  assign arm = arm_valid_i && arm_hit;
  assign arm_ready_o = arm_hit;
  assign ev_valid_o = sel_hit;
  assign ev_slot_o = sel;
  assign ev_tag_o = sel_hit ? tag_q[sel] : '0;
  assign fire_count_o = fire_count_q;
  // lowest-index free slot receives the next arm; any non-free slot means busy
  always_comb begin
    arm_hit = 1'b0;
    arm_idx = '0;
    busy_o = 1'b0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        arm_hit = 1'b1;
        arm_idx = SW'(i);
      end else busy_o = 1'b1;
    end
  end
`ifdef TIMED_EVENT_SCHEDULER_RR_EN
  logic [SW-1:0] ptr_q, ptr_d, rr_idx;
  // first pending slot at or after the pointer, wrapping around
  always_comb begin
    sel_hit = 1'b0;
    sel = '0;
    rr_idx = '0;
    for (int k = NSLOTS - 1; k >= 0; k--) begin
      rr_idx = SW'((int'(ptr_q) + k) % NSLOTS);
      if (st_q[rr_idx] == PEND) begin
        sel_hit = 1'b1;
        sel = rr_idx;
      end
    end
    ptr_d = (fire && !flush_i) ? ((sel == SW'(NSLOTS - 1)) ? '0 : sel + SW'(1)) : ptr_q;
  end
  // pointer advances past each accepted slot, survives flush
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
`else
  // fixed priority: lowest-index pending slot
  always_comb begin
    sel_hit = 1'b0;
    sel = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (st_q[i] == PEND) begin
        sel_hit = 1'b1;
        sel = SW'(i);
      end
    end
  end
`endif
  // per-slot FREE->WAIT->PEND->FREE transitions; flush overrides arm and fire
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    for (int i = 0; i < NSLOTS; i++) begin
      if (st_q[i] == WAIT && cnt_q[i] == '0) st_d[i] = PEND;
      if (st_q[i] == WAIT && cnt_q[i] != '0 && tick_i) cnt_d[i] = cnt_q[i] - DW'(1);
      if (fire && sel == SW'(i)) st_d[i] = FREE;
      if (arm && arm_idx == SW'(i)) begin
        st_d[i] = WAIT;
        cnt_d[i] = arm_delay_i;
        tag_d[i] = arm_tag_i;
      end
      if (flush_i) st_d[i] = FREE;
    end
    fire_count_d = fire_count_q + 32'(fire && !flush_i);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOTS; i++) begin
        st_q[i] <= FREE;
        cnt_q[i] <= '0;
        tag_q[i] <= '0;
      end
      fire_count_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      fire_count_q <= fire_count_d;
    end
  end
endmodule

// File: tb/tb_timed_event_scheduler.sv
// tb_timed_event_scheduler: directed checks of arming, latency, ordering, backpressure, flush and selection policy
module tb_timed_event_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b1;
  logic        arm_valid = 1'b0;
  logic        arm_ready;
  logic [15:0] arm_delay = '0;
  logic [7:0]  arm_tag = '0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [7:0]  ev_tag;
  logic [1:0]  ev_slot;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] fire_count;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  got[$];
  int          slots[4];
  int          exp_slot[4];

  timed_event_scheduler dut (
    .clk(clk), .rst(rst), .tick_i(tick), .arm_valid_i(arm_valid), .arm_ready_o(arm_ready),
    .arm_delay_i(arm_delay), .arm_tag_i(arm_tag), .ev_valid_o(ev_valid), .ev_ready_i(ev_ready),
    .ev_tag_o(ev_tag), .ev_slot_o(ev_slot), .flush_i(flush), .busy_o(busy), .fire_count_o(fire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    arm_valid = 1'b0;
    flush = 1'b0;
    ev_ready = 1'b0;
    tick = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic collect(input int want, input int max_cyc);
    int c = 0;
    while (got.size() < want && c < max_cyc) begin
      if (ev_valid) got.push_back(ev_tag);
      step;
      c++;
    end
    check("collect_timeout", 32'(got.size()), 32'(want));
  endtask

  initial begin
    int n;
`ifdef TIMED_EVENT_SCHEDULER_RR_EN
    exp_slot = '{0, 1, 2, 0};
`else
    exp_slot = '{0, 0, 0, 0};
`endif
    do_reset;
    check("rst_tag", 32'(ev_tag), 0);
    check("rst_slot", 32'(ev_slot), 0);
    for (int i = 0; i < 10; i++) begin
      step;
      check("idle_arm_ready", 32'(arm_ready), 1);
      check("idle_ev_valid", 32'(ev_valid), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_fc", fire_count, 0);
    end

    do_reset;
    ev_ready = 1'b1;
    arm_valid = 1'b1;
    arm_delay = 16'd5;
    arm_tag = 8'h11;
    step;
    arm_valid = 1'b0;
    check("single_busy", 32'(busy), 1);
    check("single_ev_early", 32'(ev_valid), 0);
    n = 0;
    while (!ev_valid && n < 50) begin
      step;
      n++;
    end
    check("single_latency", 32'(n), 6);
    check("single_tag", 32'(ev_tag), 32'h11);
    check("single_slot", 32'(ev_slot), 0);
    step;
    check("single_ev_drop", 32'(ev_valid), 0);
    check("single_fc", fire_count, 1);
    check("single_idle", 32'(busy), 0);

    do_reset;
    ev_ready = 1'b1;
    arm_valid = 1'b1;
    arm_tag = 8'hA0; arm_delay = 16'd20; step;
    arm_tag = 8'hA1; arm_delay = 16'd5;  step;
    arm_tag = 8'hA2; arm_delay = 16'd0;  step;
    arm_tag = 8'hA3; arm_delay = 16'd5;  step;
    arm_tag = 8'hEE; arm_delay = 16'd0;
    check("full_arm_ready", 32'(arm_ready), 0);
    check("full_ev_valid", 32'(ev_valid), 1);
    got.delete();
    got.push_back(ev_tag);
    step;
    arm_valid = 1'b0;
    check("refree_arm_ready", 32'(arm_ready), 1);
    check("refree_ev_valid", 32'(ev_valid), 0);
    collect(4, 40);
    if (got.size() == 4) begin
      check("order0", 32'(got[0]), 32'hA2);
      check("order1", 32'(got[1]), 32'hA1);
      check("order2", 32'(got[2]), 32'hA3);
      check("order3", 32'(got[3]), 32'hA0);
    end
    check("order_fc", fire_count, 4);
    check("order_busy", 32'(busy), 0);

    do_reset;
    tick = 1'b0;
    arm_valid = 1'b1;
    arm_delay = 16'd3;
    arm_tag = 8'h33;
    step;
    arm_valid = 1'b0;
    n = 0;
    while (!ev_valid && n < 30) begin
      tick = (n % 2 == 0);
      step;
      n++;
    end
    check("tick_latency", 32'(n), 6);
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      check("hold_valid", 32'(ev_valid), 1);
      check("hold_tag", 32'(ev_tag), 32'h33);
      check("hold_fc", fire_count, 0);
    end
    ev_ready = 1'b1;
    step;
    check("hold_accept_valid", 32'(ev_valid), 0);
    check("hold_accept_fc", fire_count, 1);

    do_reset;
    arm_valid = 1'b1;
    arm_delay = 16'd0;
    arm_tag = 8'h51; step;
    arm_tag = 8'h52; step;
    arm_tag = 8'h53; step;
    arm_tag = 8'h5F;
    check("flush_pre_valid", 32'(ev_valid), 1);
    check("flush_pre_tag", 32'(ev_tag), 32'h51);
    ev_ready = 1'b1;
    flush = 1'b1;
    step;
    flush = 1'b0;
    arm_valid = 1'b0;
    check("flush_busy", 32'(busy), 0);
    check("flush_ev_valid", 32'(ev_valid), 0);
    check("flush_fc", fire_count, 0);
    check("flush_arm_ready", 32'(arm_ready), 1);
    arm_valid = 1'b1;
    arm_tag = 8'h60;
    step;
    arm_valid = 1'b0;
    check("postflush_early", 32'(ev_valid), 0);
    step;
    check("postflush_valid", 32'(ev_valid), 1);
    check("postflush_tag", 32'(ev_tag), 32'h60);
    check("postflush_slot", 32'(ev_slot), 0);
    step;
    check("postflush_fc", fire_count, 1);

    do_reset;
    arm_valid = 1'b1;
    arm_delay = 16'd0;
    arm_tag = 8'hC0; step;
    arm_tag = 8'hC1; step;
    arm_tag = 8'hC2; step;
    arm_valid = 1'b0;
    step;
    for (int k = 0; k < 4; k++) begin
      check("sel_valid", 32'(ev_valid), 1);
      slots[k] = int'(ev_slot);
      ev_ready = 1'b1;
      step;
      ev_ready = 1'b0;
      arm_valid = 1'b1;
      arm_tag = 8'(8'hE0 + k);
      step;
      arm_valid = 1'b0;
      step;
    end
    for (int k = 0; k < 4; k++) check($sformatf("sel_slot%0d", k), 32'(slots[k]), 32'(exp_slot[k]));
    check("sel_fc", fire_count, 4);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(ev_valid), 0);
    check("midrst_fc", fire_count, 0);
    check("midrst_arm_ready", 32'(arm_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
